// File: rtl/line_memory_responder.sv
// line_memory_responder: whole-line backing memory that answers cache line-fill
// and write-back requests after a fixed access latency. A request is accepted only
// in IDLE. The block stays BUSY for DELAY cycles. Read data is returned with a
// one-cycle is_output_valid strobe in the first cycle mem_ready is high again.
// Optional feature: define LINE_MEM_STATS_EN to get completed read/write counters.
// Without it, rd_count and wr_count are tied to 0.
module line_memory_responder #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_BLOCKS = 1024,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [BLOCK_SIZE*8-1:0] din,
    output logic                    mem_ready,
    output logic                    is_output_valid,
    output logic [BLOCK_SIZE*8-1:0] dout,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);
    localparam int         LW       = BLOCK_SIZE * 8;
    localparam int         IW       = $clog2(NUM_BLOCKS);
    localparam logic [7:0] CNT_LOAD = 8'(DELAY - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q;
    logic          op_wr_q;
    logic [IW-1:0] idx_q;
    logic [LW-1:0] din_q;
    logic [LW-1:0] mem_q [NUM_BLOCKS];
    logic          vld_q;
    logic [LW-1:0] dout_q;

    logic accept;
    logic done;

    // Exactly one of read/write must be set; anything else is dropped in IDLE.
    assign accept = (state_q == IDLE) && is_input_valid && (mem_read ^ mem_write);
    // The completion edge is the one where the latency counter has run out.
    assign done   = (state_q == BUSY) && (cnt_q == 8'd0);

    // Upper address bits only alias onto the stored lines.
    logic unused_addr;
    assign unused_addr = ^addr[31:IW];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> IDLE on completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready whenever idle.
    always_comb begin
        mem_ready = (state_q == IDLE);
    end

    // Latency counter and request capture. The captured op/index/data hold through BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            din_q   <= '0;
        end else if (accept) begin
            cnt_q   <= CNT_LOAD;
            op_wr_q <= mem_write;
            idx_q   <= addr[IW-1:0];
            din_q   <= din;
        end else if (state_q == BUSY && cnt_q != 8'd0) begin
            cnt_q   <= cnt_q - 8'd1;
        end
    end

    // Line storage: cleared on reset. It is written only at a write completion,
    // so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) mem_q[i] <= '0;
        end else if (done && op_wr_q) begin
            mem_q[idx_q] <= din_q;
        end
    end

    // Read return: dout holds the last completed read. The strobe lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else begin
            vld_q <= done && !op_wr_q;
            if (done && !op_wr_q) dout_q <= mem_q[idx_q];
        end
    end

    assign is_output_valid = vld_q;
    assign dout            = dout_q;

`ifdef LINE_MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    // Completed-access counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (done) begin
            if (op_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
            else         rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder. Two instances (DELAY 50 and DELAY 1) share one
// input stream. Each instance has a timestamp-based model: a request accepted at
// edge e completes at edge e+DELAY. The model checks both instances every cycle.
// Directed sequences pin the model with literal expectations. A randomized phase follows.
module tb_line_memory_responder;
    localparam int BS = 16;
    localparam int NB = 1024;
    localparam int W  = BS * 8;
    localparam int DLY [2] = '{50, 1};
`ifdef LINE_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv = 1'b0, mr = 1'b0, mw = 1'b0;
    logic [31:0]  ad = '0;
    logic [W-1:0] di = '0;

    logic [1:0]   rdy, vld;
    logic [W-1:0] dout_w [2];
    logic [31:0]  rdc [2], wrc [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_memory_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(50)) u_slow (
        .clk(clk), .reset(rst), .is_input_valid(iv), .addr(ad), .mem_read(mr),
        .mem_write(mw), .din(di), .mem_ready(rdy[0]), .is_output_valid(vld[0]),
        .dout(dout_w[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

    line_memory_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(1)) u_fast (
        .clk(clk), .reset(rst), .is_input_valid(iv), .addr(ad), .mem_read(mr),
        .mem_write(mw), .din(di), .mem_ready(rdy[1]), .is_output_valid(vld[1]),
        .dout(dout_w[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint       edge_n = 0;
    bit           m_busy [2];
    bit           m_opwr [2];
    int           m_idx  [2];
    logic [W-1:0] m_din  [2];
    longint       m_done [2];
    bit           m_vld  [2];
    logic [W-1:0] m_dout [2];
    int unsigned  m_rd   [2], m_wr [2];
    logic [W-1:0] mm [2][NB];

    // At each edge, the model either completes the request due at this edge or takes a new legal request.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 0; m_vld[k] = 0; m_dout[k] = '0; m_rd[k] = 0; m_wr[k] = 0;
                for (int i = 0; i < NB; i++) mm[k][i] = '0;
            end else begin
                m_vld[k] = 0;
                if (m_busy[k]) begin
                    if (edge_n == m_done[k]) begin
                        m_busy[k] = 0;
                        if (m_opwr[k]) begin
                            mm[k][m_idx[k]] = m_din[k];
                            m_wr[k]++;
                        end else begin
                            m_dout[k] = mm[k][m_idx[k]];
                            m_vld[k]  = 1;
                            m_rd[k]++;
                        end
                    end
                end else if (iv && (mr != mw)) begin
                    m_busy[k] = 1;
                    m_opwr[k] = mw;
                    m_idx[k]  = int'(ad % NB);
                    m_din[k]  = di;
                    m_done[k] = edge_n + DLY[k];
                end
            end
        end
        edge_n++;
    end

    // Compare both instances against the model, every cycle, away from the edge.
    always @(negedge clk) begin
        if (edge_n > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k), W'(rdy[k]), W'(!m_busy[k]));
                chk($sformatf("valid[%0d]", k), W'(vld[k]), W'(m_vld[k]));
                chk($sformatf("dout[%0d]", k), dout_w[k], m_dout[k]);
                chk($sformatf("rd_count[%0d]", k), W'(rdc[k]), STATS ? W'(m_rd[k]) : '0);
                chk($sformatf("wr_count[%0d]", k), W'(wrc[k]), STATS ? W'(m_wr[k]) : '0);
            end
        end
    end

    // ---------------- directed helpers ----------------
    int           lowcyc;
    bit           fast_low, fast_back, sv, sv_next;
    logic [W-1:0] sd;

    // Wait for slow instance idle, present one request for one cycle.
    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [W-1:0] d);
        int n = 0;
        while (!rdy[0] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("wait_ready_timeout", '0, W'(1));
        iv = 1; mr = r; mw = w; ad = a; di = d;
        @(negedge clk);
        iv = 0; mr = 0; mw = 0;
        fast_low = !rdy[1];
    endtask

    // Count ready-low cycles of the slow instance and capture the strobe when ready returns.
    task automatic finish();
        lowcyc = 0; fast_back = 0;
        while (!rdy[0] && lowcyc < 300) begin
            lowcyc++;
            @(negedge clk);
            if (lowcyc == 1) fast_back = rdy[1];
        end
        sv = vld[0]; sd = dout_w[0];
        @(negedge clk);
        sv_next = vld[0];
    endtask

    task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [W-1:0] d);
        issue(r, w, a, d);
        finish();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    localparam logic [W-1:0] K = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [W-1:0] A = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [W-1:0] B = 128'hBBBB_9999_8888_7777_6666_5555_4444_3333;
    localparam logic [W-1:0] X = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
    localparam logic [W-1:0] Y = 128'h7777_7777_7777_7777_7777_7777_7777_7777;

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset_ready", W'(rdy[0]), W'(1));
        chk("reset_valid", W'(vld[0]), '0);
        chk("reset_dout", dout_w[0], '0);

        // Write then read index 5, with latency checks on both instances.
        issue(1'b0, 1'b1, 32'd5, K);
        chk("fast_low_first", W'(fast_low), W'(1));
        finish();
        chk("fast_back_second", W'(fast_back), W'(1));
        chk("write_latency50", W'(lowcyc), W'(50));
        chk("write_no_strobe", W'(sv), '0);
        do_req(1'b1, 1'b0, 32'd5, '0);
        chk("read_latency50", W'(lowcyc), W'(50));
        chk("read_strobe", W'(sv), W'(1));
        chk("read5_data", sd, K);
        chk("strobe_one_cycle", W'(sv_next), '0);

        // A request presented while busy is ignored.
        issue(1'b0, 1'b1, 32'd3, A);
        iv = 1; mw = 1; ad = 32'd3; di = B;
        @(negedge clk);
        iv = 0; mw = 0;
        finish();
        do_req(1'b1, 1'b0, 32'd3, '0);
        chk("busy_ignored", sd, A);

        // Illegal requests: both op bits set, and neither set.
        do_req(1'b1, 1'b1, 32'd3, B);
        chk("illegal_both_ready", W'(lowcyc), '0);
        chk("illegal_both_nostrobe", W'(sv), '0);
        do_req(1'b0, 1'b0, 32'd3, B);
        chk("illegal_none_ready", W'(lowcyc), '0);

        // Upper address bits alias onto the same line.
        do_req(1'b0, 1'b1, 32'h405, X);
        do_req(1'b1, 1'b0, 32'h005, '0);
        chk("alias_read", sd, X);

        // Reset in the middle of a write discards the write.
        issue(1'b0, 1'b1, 32'd7, Y);
        repeat (19) @(negedge clk);
        do_reset();
        chk("post_reset_ready", W'(rdy[0]), W'(1));
        chk("post_reset_valid", W'(vld[0]), '0);
        chk("post_reset_dout", dout_w[0], '0);
        do_req(1'b1, 1'b0, 32'd7, '0);
        chk("aborted_write_read", sd, '0);
        chk("aborted_write_strobe", W'(sv), W'(1));

        // Stats: 3 reads and 2 writes after a clean reset.
        do_reset();
        do_req(1'b0, 1'b1, 32'd1, A);
        do_req(1'b1, 1'b0, 32'd1, '0);
        do_req(1'b0, 1'b1, 32'd2, B);
        do_req(1'b1, 1'b0, 32'd2, '0);
        do_req(1'b1, 1'b0, 32'd1, '0);
        chk("stats_rd", W'(rdc[0]), STATS ? W'(3) : '0);
        chk("stats_wr", W'(wrc[0]), STATS ? W'(2) : '0);
        chk("stats_rd_fast", W'(rdc[1]), STATS ? W'(3) : '0);

        // Randomized traffic with a few line indices, so accesses collide often.
        // Upper address bits are randomized to exercise aliasing. Occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       begin mr = 1; mw = 1; end
                1:       begin mr = 0; mw = 0; end
                2, 3, 4, 5: begin mr = 1; mw = 0; end
                default: begin mr = 0; mw = 1; end
            endcase
            ad = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
            di = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        rst = 0; iv = 0; mr = 0; mw = 0;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/line_memory_responder.md
# line_memory_responder

Block-granular backing memory that answers the line-fill and write-back requests issued by the lab cache controllers. It accepts one whole-line read or write per request and drops `mem_ready` for a fixed, parameterised latency. It returns read data as a full line with a one-cycle `is_output_valid` strobe. It sits below the cache, in place of the lab-supplied data memory, as the responder end of the cache↔memory line interface.

## Interface
- `BLOCK_SIZE`, default 16: line size in bytes; data ports are `BLOCK_SIZE*8` bits wide.
- `NUM_BLOCKS`, default 1024: number of lines stored; power of two.
- `DELAY`, default 50: access latency in cycles; legal range 1..255.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `is_input_valid` input 1: request present.
- `addr` input 32: line address, already shifted right by CLOG2(`BLOCK_SIZE`).
- `mem_read` input 1: request is a line read.
- `mem_write` input 1: request is a line write.
- `din` input `BLOCK_SIZE*8`: write line data.
- `mem_ready` output 1: responder idle, able to accept a request.
- `is_output_valid` output 1: `dout` carries the completed read; one-cycle strobe.
- `dout` output `BLOCK_SIZE*8`: read line data.
- `rd_count` output 32: completed-read counter (see Configuration).
- `wr_count` output 32: completed-write counter (see Configuration).

## Operation
- The FSM has two states, IDLE and BUSY.
- `mem_ready` = (state == IDLE), driven combinationally from the state register.
- **Acceptance:** a request is accepted at a rising edge in IDLE when `is_input_valid` is 1 and exactly one of `mem_read`/`mem_write` is 1. On acceptance:
  - latch the op, the index and `din`;
  - load an 8-bit down-counter with `DELAY-1`;
  - go to BUSY.
- **Illegal requests:** if `mem_read` and `mem_write` are both 1, or both 0, the request is ignored and the block stays in IDLE. Nothing is latched.
- **Index:** `addr[CLOG2(NUM_BLOCKS)-1:0]`. Upper address bits are ignored, so addresses alias modulo `NUM_BLOCKS`.
- **BUSY:**
  - All inputs are ignored.
  - At each edge with counter != 0, the counter decrements.
  - At the edge with counter == 0 (the completion edge), the access is performed and the state returns to IDLE.
- **Read completion:**
  - `dout` <= array[index] and `is_output_valid` <= 1.
  - `dout` holds that value until the next read completes.
- **Write completion:**
  - array[index] <= latched `din`.
  - `is_output_valid` stays 0 and `dout` is unchanged.
- `is_output_valid` deasserts at the edge after it rises.
- Read data always reflects all writes completed earlier, including a write to the same index that completed on the immediately preceding request.
- **Reset:**
  - state = IDLE, counter = 0, `is_output_valid` = 0, `dout` = 0, every array line = 0, `rd_count` = `wr_count` = 0.
  - `mem_ready` = 1 in the first cycle after reset.
  - Reset in BUSY aborts the operation. A pending write is discarded and no strobe is produced.

## Timing
- Acceptance edge E0 → `mem_ready` = 0 for exactly `DELAY` cycles.
- The completion edge is E0+`DELAY`. In the following cycle:
  - `mem_ready` = 1;
  - for a read, `is_output_valid` = 1 and `dout` is valid.
- Consequence: a requester may sample `dout` in the first cycle `mem_ready` returns high.
- With `DELAY` = 1, `mem_ready` is low for one cycle only.
- Back-to-back requests: a new request can be accepted in the same cycle that `is_output_valid` is high. Minimum request spacing is therefore `DELAY`+1 edges.
- There is no combinational path from `is_input_valid`, `addr` or `din` to any output.

## Configuration
- Macro: `LINE_MEM_STATS_EN`.
- **Defined:**
  - `rd_count` increments by 1 at each read completion edge.
  - `wr_count` increments by 1 at each write completion edge.
  - Both counters wrap at 2^32 and clear on reset.
- **Undefined:**
  - `rd_count` and `wr_count` are tied to constant 0.
  - No counter flops are synthesised.
  - All other behaviour is identical.

## Test plan
- **Write then read:** write index 5, `din` = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, then read index 5 → `dout` equals that value, with a 1-cycle `is_output_valid` coinciding with `mem_ready` rising.
- **Latency:** with `DELAY` = 50, read accepted at cycle 10 → `mem_ready` low during cycles 11–60, and `is_output_valid` = 1 in cycle 61 only. With `DELAY` = 1, `mem_ready` low in cycle 11 only.
- **Busy and illegal requests ignored:**
  - Write index 3 = A. While BUSY, present write index 3 = B. Read index 3 → A.
  - Present `mem_read` = `mem_write` = 1 in IDLE → `mem_ready` stays 1 and no strobe.
- **Aliasing:** with `NUM_BLOCKS` = 1024, write addr 0x405 = X, read addr 0x005 → X.
- **Reset:**
  - Assert reset 20 cycles into a write to index 7 = Y, then read index 7 → 0.
  - After reset, `dout` = 0, `is_output_valid` = 0, `mem_ready` = 1.
- **Stats:**
  - With `LINE_MEM_STATS_EN`, 3 reads and 2 writes → `rd_count` = 3, `wr_count` = 2.
  - Without the macro, the same sequence → both 0.
